pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Sequencing controller for the decode stage. Generates the stall and squash inputs consumed by stage_decode.
- Keeps a load scoreboard, because load results are not forwardable from exe, and only the exe ALU result is forwarded.
- Runs a jump FSM that holds issue until the jump resolves in exe, then flushes younger instructions.
- Sits beside the decode stage. Decode-field inputs come from the instruction decoder; resolution and writeback inputs come from exe and wb.

Parameters:
- MAX_LOADS, 4: maximum outstanding loads in flight (1..15).
- SQUASH_CYCLES, 2: cycles squash is held after a taken jump (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- dec_valid  in  1  decode holds a real (non-no-op) instruction.
- dec_rs0  in  5  first source register.
- dec_rs0_used  in  1  dec_rs0 is read.
- dec_rs1  in  5  second source register.
- dec_rs1_used  in  1  dec_rs1 is read.
- dec_rd  in  5  destination register.
- dec_writes  in  1  instruction writes dec_rd.
- dec_is_load  in  1  instruction is a memory load.
- dec_is_jump  in  1  instruction is a jump.
- wb_load_valid  in  1  a load result is written back this cycle.
- wb_load_reg  in  5  register written by that load.
- jump_resolved  in  1  exe has evaluated the outstanding jump.
- jump_taken  in  1  qualifies jump_resolved.
- stall  out  1  hold decode and insert a no-op (combinational).
- squash  out  1  kill the decode/exe instructions (registered).
- pending  out  32  scoreboard; bit n set means a load to rn is outstanding.
- load_count  out  4  number of outstanding loads.
- ctrl_state  out  2  FSM state: 0=RUN, 1=JUMP_WAIT, 2=FLUSH.
- sb_error  out  1  sticky: writeback seen with no matching pending load.

Behaviour:
- Reset (rst==0 at a clk edge) clears pending, load_count, sb_error and squash, and forces ctrl_state=RUN. Reset mid-jump or mid-flush aborts the operation immediately. stall=0 while rst==0.
- An entry is "effectively pending" when pending[r] is set and not (wb_load_valid && wb_load_reg==r). The register file writes through, so a same-cycle writeback clears the hazard. All 32 registers are tracked; r0 gets no special treatment.
- hazard is raised when any of these holds:
  - dec_rs0_used and rs0 is effectively pending;
  - dec_rs1_used and rs1 is effectively pending;
  - dec_writes and rd is effectively pending (WAW);
  - dec_is_load and load_count==MAX_LOADS and no wb_load_valid this cycle.
- stall = dec_valid && (hazard || ctrl_state==JUMP_WAIT). stall is forced to 0 when ctrl_state==FLUSH, because squash dominates.
- issue = dec_valid && !stall && ctrl_state==RUN.
- Scoreboard update:
  - issue of a load sets pending[dec_rd].
  - wb_load_valid clears pending[wb_load_reg]. If both target the same register in one cycle, the set wins.
  - load_count next = load_count + (load issue) - (valid wb); it never goes below 0 or above MAX_LOADS.
  - wb_load_valid with the pending bit clear, or with load_count==0, sets sb_error and leaves pending and load_count unchanged.
- FSM transitions:
  - RUN: issue with dec_is_jump goes to JUMP_WAIT next cycle. jump_resolved is ignored in RUN.
  - JUMP_WAIT: jump_resolved && jump_taken goes to FLUSH and loads the flush counter with SQUASH_CYCLES. jump_resolved && !jump_taken goes to RUN. With no resolution, stay in JUMP_WAIT indefinitely.
  - FLUSH: squash=1 on every cycle in FLUSH. The counter decrements each cycle and the FSM returns to RUN when it reaches 1. squash is therefore high for exactly SQUASH_CYCLES consecutive cycles, starting the cycle after resolution.
- A load issued just before a jump stays pending through FLUSH and is not cancelled. Writebacks are processed in every state.
- Latency:
  - stall responds in the same cycle as its inputs.
  - Scoreboard, count and FSM update at the next edge.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- When defined, add outputs stall_cycles (32-bit) and squash_events (16-bit). Both are cleared by reset and saturate at all-ones.
  - stall_cycles increments every cycle stall==1.
  - squash_events increments once per entry into FLUSH.
- When undefined, these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Load-use:
  - Issue a load to r5, then present dec_rs0=5, used=1 -> stall=1 each cycle.
  - Apply wb_load_valid with reg=5 -> stall=0 in that same cycle; pending[5]=0 and load_count=0 at the next edge.
- Outstanding-load limit: issue 4 loads to r1..r4 with MAX_LOADS=4 -> load_count=4. A 5th load to r6 stalls until a writeback, and issues in the same cycle as that writeback.
- Taken jump:
  - Issue a jump -> ctrl_state=1 and stall=1 with dec_valid held.
  - Apply jump_resolved=1, jump_taken=1 -> squash=1 for exactly 2 cycles, then ctrl_state=0.
- Not-taken jump: jump_resolved=1, jump_taken=0 while in JUMP_WAIT -> back in RUN next cycle, squash never asserted.
- Boundary and errors:
  - Set and clear of r7 in the same cycle -> pending[7]=1.
  - wb_load_valid to r9 with pending[9]=0 -> sb_error=1, sticky until reset.
  - Reset asserted while in FLUSH -> all outputs 0 and ctrl_state=0 next cycle.
- With HAZARD_PERF_COUNTERS_EN defined: a 3-cycle load-use stall followed by one taken jump -> squash_events=1, and stall_cycles equals the total count of stall-high cycles.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: decode-stage stall/squash sequencing with a load scoreboard and jump FSM.
// Optional outputs stall_cycles/squash_events are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
    parameter int MAX_LOADS     = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs0,
    input  logic        dec_rs0_used,
    input  logic [4:0]  dec_rs1,
    input  logic        dec_rs1_used,
    input  logic [4:0]  dec_rd,
    input  logic        dec_writes,
    input  logic        dec_is_load,
    input  logic        dec_is_jump,
    input  logic        wb_load_valid,
    input  logic [4:0]  wb_load_reg,
    input  logic        jump_resolved,
    input  logic        jump_taken,
    output logic        stall,
    output logic        squash,
    output logic [31:0] pending,
    output logic [3:0]  load_count,
    output logic [1:0]  ctrl_state,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] squash_events,
`endif
    output logic        sb_error
);
    typedef enum logic [1:0] {RUN = 2'd0, JUMP_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    state_t      r_state, w_next_state;
    logic [2:0]  r_flush_cnt, w_flush_next;
    logic [31:0] r_pending, w_pending_next, w_wb_mask, w_eff_pend;
    logic [3:0]  r_load_count, w_count_next;
    logic [4:0]  w_count_sum;
    logic        r_squash, r_sb_error;
    logic        w_hazard, w_issue, w_load_issue, w_wb_ok, w_wb_err;

    // Register file writes through, so a same-cycle writeback already resolves the hazard.
    assign w_wb_mask  = wb_load_valid ? (32'd1 << wb_load_reg) : 32'd0;
    assign w_eff_pend = r_pending & ~w_wb_mask;
    assign w_hazard   = (dec_rs0_used && w_eff_pend[dec_rs0]) ||
                        (dec_rs1_used && w_eff_pend[dec_rs1]) ||
                        (dec_writes && w_eff_pend[dec_rd]) ||
                        (dec_is_load && r_load_count == 4'(MAX_LOADS) && !wb_load_valid);

    assign stall        = rst && dec_valid && r_state != FLUSH && (w_hazard || r_state == JUMP_WAIT);
    assign w_issue      = dec_valid && !stall && r_state == RUN;
    assign w_load_issue = w_issue && dec_is_load;
    assign w_wb_ok      = wb_load_valid && r_pending[wb_load_reg] && r_load_count != 4'd0;
    assign w_wb_err     = wb_load_valid && !w_wb_ok;

    assign w_pending_next = (r_pending & ~(w_wb_ok ? w_wb_mask : 32'd0)) |
                            (w_load_issue ? (32'd1 << dec_rd) : 32'd0);
    assign w_count_sum    = {1'b0, r_load_count} + 5'(w_load_issue) - 5'(w_wb_ok);
    assign w_count_next   = w_count_sum > 5'(MAX_LOADS) ? 4'(MAX_LOADS) : w_count_sum[3:0];

    always_comb begin
        w_next_state = r_state;
        w_flush_next = r_flush_cnt;
        case (r_state)
            RUN:       if (w_issue && dec_is_jump) w_next_state = JUMP_WAIT;
            JUMP_WAIT: if (jump_resolved) begin
                w_next_state = jump_taken ? FLUSH : RUN;
                w_flush_next = 3'(SQUASH_CYCLES);
            end
            FLUSH: begin
                w_flush_next = r_flush_cnt - 3'd1;
                w_next_state = r_flush_cnt == 3'd1 ? RUN : FLUSH;
            end
            default:   w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= RUN;
            r_flush_cnt  <= 3'd0;
            r_pending    <= 32'd0;
            r_load_count <= 4'd0;
            r_squash     <= 1'b0;
            r_sb_error   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_flush_cnt  <= w_flush_next;
            r_pending    <= w_pending_next;
            r_load_count <= w_count_next;
            r_squash     <= w_next_state == FLUSH;
            r_sb_error   <= r_sb_error | w_wb_err;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_squash_events;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles  <= 32'd0;
            r_squash_events <= 16'd0;
        end else begin
            if (stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (r_state == JUMP_WAIT && w_next_state == FLUSH && r_squash_events != '1)
                r_squash_events <= r_squash_events + 16'd1;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign squash_events = r_squash_events;
`endif

    assign squash     = r_squash;
    assign pending    = r_pending;
    assign load_count = r_load_count;
    assign ctrl_state = r_state;
    assign sb_error   = r_sb_error;
endmodule
